// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: format codes, field placement
// constants and the default error-counter width.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_D  = 2'b00,
    FMT_I  = 2'b01,
    FMT_CB = 2'b10,
    FMT_B  = 2'b11
  } fmt_e;

  localparam logic [4:0] D_LSB  = 5'd12;
  localparam logic [4:0] D_W    = 5'd9;
  localparam logic [4:0] I_LSB  = 5'd10;
  localparam logic [4:0] I_W    = 5'd12;
  localparam logic [4:0] CB_LSB = 5'd5;
  localparam logic [4:0] CB_W   = 5'd19;
  localparam logic [4:0] B_LSB  = 5'd0;
  localparam logic [4:0] B_W    = 5'd26;

  localparam int ERR_W_DEFAULT = 8;

  function automatic logic [31:0] field_mask(input logic [4:0] lsb, input logic [4:0] w);
    return ((32'd1 << w) - 32'd1) << lsb;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range check and field alignment of a 64-bit immediate for the
// selected instruction format.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [1:0]         fmt,
  input  logic signed [63:0] imm,
  output logic               range_err,
  output logic [31:0]        field,
  output logic [31:0]        mask
);

  logic [4:0]         lsb;
  logic [4:0]         width;
  logic signed [63:0] hi;

  always_comb begin
    lsb   = D_LSB;
    width = D_W;
    case (fmt)
      FMT_I:   begin lsb = I_LSB;  width = I_W;  end
      FMT_CB:  begin lsb = CB_LSB; width = CB_W; end
      FMT_B:   begin lsb = B_LSB;  width = B_W;  end
      default: begin lsb = D_LSB;  width = D_W;  end
    endcase
  end

  // Signed fields fit when everything from the field's sign bit up is one copy
  // of that sign bit; the unsigned I field fits when nothing above bit 11 is set.
  always_comb begin
    hi = imm >>> (width - 5'd1);
    if (fmt == FMT_I)
      range_err = |imm[63:12];
    else
      range_err = !((hi == '0) || (&hi));
    mask  = field_mask(lsb, width);
    field = (imm[31:0] << lsb) & mask;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined immediate encoder: packs a 64-bit immediate into the
// field of an instruction word, flags out-of-range values and counts them.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         fmt,
  input  logic [31:0]        base_instr,
  input  logic signed [63:0] imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic               range_err,
  output logic [ERR_W-1:0]   err_count
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] merge_field(input logic [31:0] base,
                                              input logic [31:0] field,
                                              input logic [31:0] mask);
    return (base & ~mask) | field;
  endfunction

  logic        err_c;
  logic [31:0] field_c;
  logic [31:0] mask_c;

  logic        vld_p1;
  logic        err_p1;
  logic [31:0] field_p1;
  logic [31:0] mask_p1;
  logic [31:0] base_p1;

  logic adv_p1;
  logic adv_p2;

  assign adv_p2   = !out_valid || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;

  imm_range_check u_range_check (
    .fmt       (fmt),
    .imm       (imm),
    .range_err (err_c),
    .field     (field_c),
    .mask      (mask_c)
  );

  // Stage 1: range check result and field-aligned immediate
  always_ff @(posedge clk) begin
    if (in_valid && adv_p1) begin
      err_p1   <= err_c;
      field_p1 <= field_c;
      mask_p1  <= mask_c;
      base_p1  <= base_instr;
    end
  end

  // Stage 2: merged instruction word and error flag; out_valid is its valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      instr     <= '0;
      range_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (adv_p1)
        vld_p1 <= in_valid;
      if (adv_p2)
        out_valid <= vld_p1;
      if (vld_p1 && adv_p2) begin
        instr     <= merge_field(base_p1, field_p1, mask_p1);
        range_err <= err_p1;
      end
      if (out_valid && out_ready && range_err)
        err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed table, randomized stream with a
// queue-based reference model, saturation and mid-flight reset sequences.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = 2'b00;
  logic [31:0] base_instr = '0;
  logic [63:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        range_err;
  logic [7:0]  err_count;

  imm_encoder #(.ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .base_instr (base_instr),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .range_err  (range_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] instr;
    logic        err;
    logic [63:0] imm;
  } exp_t;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] base;
    logic [63:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          mcount = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_instr;
  logic        prev_err;
  bit          delivered;
  logic [31:0] last_instr;
  logic        last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fparams(input logic [1:0] f, output int lsb, output int n, output bit sg);
    case (f)
      2'b00:   begin lsb = 12; n = 9;  sg = 1; end
      2'b01:   begin lsb = 10; n = 12; sg = 0; end
      2'b10:   begin lsb = 5;  n = 19; sg = 1; end
      default: begin lsb = 0;  n = 26; sg = 1; end
    endcase
  endfunction

  // Reference: representable range by arithmetic, field = imm modulo 2^n.
  function automatic void model(input logic [1:0] f, input logic [31:0] b, input logic [63:0] v,
                                output logic [31:0] ins, output logic e);
    int lsb, n; bit sg;
    longint s, lo, hi;
    fparams(f, lsb, n, sg);
    s = longint'(v);
    if (sg) begin
      lo = -(longint'(1) << (n - 1));
      hi = (longint'(1) << (n - 1)) - 1;
      e = !(s >= lo && s <= hi);
    end else begin
      e = !(v < 64'd4096);
    end
    ins = b;
    for (int k = 0; k < n; k++) ins[lsb + k] = v[k];
  endfunction

  // Sign extender: the decoding direction the encoder must invert.
  function automatic longint sext(input logic [1:0] f, input logic [31:0] w);
    int lsb, n; bit sg;
    longint v;
    fparams(f, lsb, n, sg);
    v = longint'((w >> lsb) & ((32'd1 << n) - 32'd1));
    if (sg && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    return v;
  endfunction

  function automatic logic [63:0] rand_imm(input logic [1:0] f);
    int lsb, n; bit sg;
    longint lo, hi, span;
    fparams(f, lsb, n, sg);
    if (sg) begin
      lo = -(longint'(1) << (n - 1));
      hi = (longint'(1) << (n - 1)) - 1;
    end else begin
      lo = 0;
      hi = 4095;
    end
    span = hi - lo + 1;
    case ($urandom_range(0, 5))
      0: return lo;
      1: return hi;
      2: return lo - 1;
      3: return hi + 1;
      4: return {$urandom, $urandom};
      default: return lo + (longint'($urandom) % span);
    endcase
  endfunction

  task automatic step(input bit v, input logic [1:0] f, input logic [31:0] b,
                      input logic [63:0] i, input bit ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; fmt = f; base_instr = b; imm = i; out_ready = ordy;
    #1;
    delivered = 0;
    chk("in_ready", in_ready, (exp_q.size() < 2) || ordy);
    chk("err_count", err_count, mcount);
    if (exp_q.size() == 0) chk("out_valid_idle", out_valid, 0);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_instr", instr, prev_instr);
      chk("hold_err", range_err, prev_err);
    end
    if (out_valid && ordy && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("instr", instr, e.instr);
      chk("range_err", range_err, e.err);
      if (!e.err) chk("roundtrip", sext(e.f, instr), e.imm);
      if (e.err && mcount < 255) mcount++;
      delivered = 1;
      last_instr = instr;
      last_err = range_err;
    end
    prev_stall = out_valid && !ordy;
    prev_instr = instr;
    prev_err = range_err;
    if (v && in_ready) begin
      e.f = f; e.imm = i;
      model(f, b, i, e.instr, e.err);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0;
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    mcount = 0;
    prev_stall = 0;
  endtask

  // Single request with out_ready high; returns cycles from acceptance to out_valid.
  task automatic single(input logic [1:0] f, input logic [31:0] b, input logic [63:0] i,
                        output int lat);
    int cnt;
    step(1, f, b, i, 1);
    cnt = 0;
    do begin
      step(0, 2'b00, 32'd0, 64'd0, 1);
      cnt++;
    end while (!delivered && cnt < 10);
    lat = cnt;
  endtask

  vec_t tbl[5];

  initial begin
    int lat;
    int guard;
    tbl[0] = '{2'b00, 32'hF840_0000, -64'sd5,  32'hF85F_B000, 1'b0};
    tbl[1] = '{2'b01, 32'h9100_0000, 64'd4095, 32'h913F_FC00, 1'b0};
    tbl[2] = '{2'b01, 32'h9100_0000, 64'd4096, 32'h9100_0000, 1'b1};
    tbl[3] = '{2'b11, 32'h1400_0000, -64'sd1,  32'h17FF_FFFF, 1'b0};
    tbl[4] = '{2'b10, 32'hB400_0000, 64'd262144, 32'hB480_0000, 1'b1};

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    reset = 0;

    foreach (tbl[k]) begin
      single(tbl[k].f, tbl[k].base, tbl[k].imm, lat);
      chk("tbl_latency", lat, 2);
      chk("tbl_instr", last_instr, tbl[k].exp_instr);
      chk("tbl_err", last_err, tbl[k].exp_err);
    end

    // Randomized stream under random backpressure
    for (int n = 0; n < 400; n++) begin
      logic [1:0] f;
      f = 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, f, $urandom, rand_imm(f), $urandom_range(0, 1) == 1);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      step(0, 2'b00, 32'd0, 64'd0, 1);
      guard++;
    end
    chk("drain_random", exp_q.size(), 0);

    // 300 out-of-range results saturate the 8-bit counter
    do_reset();
    for (int n = 0; n < 300; n++)
      step(1, 2'($urandom_range(0, 3)), $urandom, {31'd0, 1'b1, $urandom}, 1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      step(0, 2'b00, 32'd0, 64'd0, 1);
      guard++;
    end
    chk("drain_sat", exp_q.size(), 0);
    step(0, 2'b00, 32'd0, 64'd0, 1);
    chk("err_count_sat", err_count, 255);

    // Reset asserted mid-cycle with two requests in flight
    step(1, 2'b01, 32'h9100_0000, 64'd5000, 0);
    step(1, 2'b01, 32'h9100_0000, 64'd6000, 0);
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    #1;
    chk("inflight_valid", out_valid, 1);
    #1;
    reset = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_range_err", range_err, 0);
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    mcount = 0;
    prev_stall = 0;
    step(0, 2'b00, 32'd0, 64'd0, 0);
    chk("in_ready_after_rst", in_ready, 1);
    for (int n = 0; n < 5; n++) step(0, 2'b00, 32'd0, 64'd0, 1);
    single(2'b00, 32'hF840_0000, -64'sd5, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_instr", last_instr, 32'hF85F_B000);
    chk("post_rst_err", last_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
